// File: rtl/quiz_buzzer_controller.sv
// Quiz buzzer round controller: first-press detection with round-robin
// tie-break, false-start fouls and round timeout, sequenced by arm/clear.
module quiz_buzzer_controller #(
    parameter int N_PLAYERS      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         clear,
    input  logic [N_PLAYERS-1:0]         buzz,
    output logic                         armed,
    output logic                         winner_valid,
    output logic [$clog2(N_PLAYERS)-1:0] winner_id,
    output logic [N_PLAYERS-1:0]         winner_onehot,
    output logic                         timeout,
    output logic [N_PLAYERS-1:0]         foul
);

    localparam int IDW = $clog2(N_PLAYERS);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_MAX = IDW'(N_PLAYERS - 1);
    localparam logic [IDW:0]   N_EXT  = (IDW + 1)'(N_PLAYERS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_WON     = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_PLAYERS-1:0] buzz_q;
    logic [N_PLAYERS-1:0] foul_q, foul_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       win_id_q, win_id_d;
    logic [TW-1:0]        timer_q, timer_d;

    logic [N_PLAYERS-1:0] press;
    logic [N_PLAYERS-1:0] eligible;
    logic                 found;
    logic [IDW-1:0]       pick;
    logic [IDW:0]         cand;

    // Rising-edge detect on the already-synchronous buttons; fouled players are never eligible
    always_comb begin
        press    = buzz & ~buzz_q;
        eligible = press & ~foul_q;
    end

    // Round-robin search starting at ptr: first eligible player in wrap-around order
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_PLAYERS; k++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && eligible[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    // Next-state logic; clear overrides everything, including arm, presses and expiry
    always_comb begin
        state_d  = state_q;
        foul_d   = foul_q;
        ptr_d    = ptr_q;
        win_id_d = win_id_q;
        timer_d  = timer_q;
        if (clear) begin
            state_d  = S_IDLE;
            foul_d   = '0;
            win_id_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Any press before the round opens is a false start
                    foul_d = foul_q | press;
                    if (arm) begin
                        state_d = S_ARMED;
                        timer_d = '0;
                    end
                end
                S_ARMED: begin
                    // A win in the final count cycle beats expiry
                    if (found) begin
                        state_d  = S_WON;
                        win_id_d = pick;
                        ptr_d    = (pick == ID_MAX) ? '0 : pick + IDW'(1);
                    end else if (timer_q == TMAX) begin
                        state_d = S_EXPIRED;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WON, S_EXPIRED: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and latched registers; buzz_q resets high so a button held through reset is not a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            buzz_q   <= '1;
            foul_q   <= '0;
            ptr_q    <= '0;
            win_id_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            buzz_q   <= buzz;
            foul_q   <= foul_d;
            ptr_q    <= ptr_d;
            win_id_q <= win_id_d;
            timer_q  <= timer_d;
        end
    end

    // Outputs decoded purely from registers, so no input reaches an output combinationally
    always_comb begin
        armed         = (state_q == S_ARMED);
        winner_valid  = (state_q == S_WON);
        winner_id     = (state_q == S_WON) ? win_id_q : '0;
        winner_onehot = (state_q == S_WON) ? (N_PLAYERS'(1) << win_id_q) : '0;
        timeout       = (state_q == S_EXPIRED);
        foul          = foul_q;
    end

endmodule

// File: tb/tb_quiz_buzzer_controller.sv
// Self-checking bench for quiz_buzzer_controller (N=4, timeout 16).
module tb_quiz_buzzer_controller;

    localparam int N = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] buzz = 4'b0000;
    logic       armed, winner_valid, timeout;
    logic [1:0] winner_id;
    logic [3:0] winner_onehot, foul;

    quiz_buzzer_controller #(.N_PLAYERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .buzz(buzz),
        .armed(armed), .winner_valid(winner_valid), .winner_id(winner_id),
        .winner_onehot(winner_onehot), .timeout(timeout), .foul(foul)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       armed;
        logic       wv;
        logic [1:0] id;
        logic [3:0] oh;
        logic       to;
        logic [3:0] foul;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state: 0 idle, 1 armed, 2 won, 3 expired
    int         m_state;
    logic [3:0] m_foul, m_bq;
    int         m_ptr, m_win, m_timer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_foul = 4'b0; m_bq = 4'hF; m_ptr = 0; m_win = 0; m_timer = 0;
    endtask

    task automatic model_step(input logic a, input logic c, input logic [3:0] b);
        logic [3:0] pr, el;
        int ns;
        bit hit;
        exp_t e;
        pr = b & ~m_bq;
        ns = m_state;
        if (c) begin
            ns = 0; m_foul = 4'b0; m_win = 0;
        end else if (m_state == 0) begin
            m_foul = m_foul | pr;
            if (a) begin ns = 1; m_timer = 0; end
        end else if (m_state == 1) begin
            el = pr & ~m_foul;
            if (el != 4'b0) begin
                hit = 0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && el[(m_ptr + k) % N]) begin
                        hit = 1;
                        m_win = (m_ptr + k) % N;
                    end
                end
                m_ptr = (m_win + 1) % N;
                ns = 2;
            end else if (m_timer == T - 1) begin
                ns = 3;
            end else begin
                m_timer++;
            end
        end
        m_state = ns;
        m_bq = b;
        e.armed = (ns == 1);
        e.wv    = (ns == 2);
        e.id    = (ns == 2) ? 2'(m_win) : 2'd0;
        e.oh    = (ns == 2) ? (4'b0001 << m_win) : 4'b0000;
        e.to    = (ns == 3);
        e.foul  = m_foul;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict, then compare the DUT after the edge
    task automatic step(input logic a, input logic c, input logic [3:0] b);
        exp_t e;
        @(negedge clk);
        arm = a; clear = c; buzz = b;
        model_step(a, c, b);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("armed", armed, e.armed);
            check("winner_valid", winner_valid, e.wv);
            check("winner_id", winner_id, e.id);
            check("winner_onehot", winner_onehot, e.oh);
            check("timeout", timeout, e.to);
            check("foul", foul, e.foul);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_armed", armed, 0);
        check("rst_wv", winner_valid, 0);
        check("rst_id", winner_id, 0);
        check("rst_oh", winner_onehot, 0);
        check("rst_timeout", timeout, 0);
        check("rst_foul", foul, 0);
        rst_n = 1'b1;
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0000);

        // Single winner, later presses ignored
        step(1, 0, 4'b0000);
        check("arm_armed", armed, 1);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0100);
        check("single_id", winner_id, 2);
        check("single_oh", winner_onehot, 4'b0100);
        check("single_armed_drop", armed, 0);
        step(0, 0, 4'b1111);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b1011);
        check("single_hold_id", winner_id, 2);

        // Async reset pulse while WON; ptr back to 0
        #2 rst_n = 1'b0;
        #1;
        check("arst_wv", winner_valid, 0);
        check("arst_oh", winner_onehot, 0);
        check("arst_foul", foul, 0);
        #1 rst_n = 1'b1;
        model_reset();
        step(0, 0, 4'b0000);

        // Tie rotation: 1, then 3, then 1
        for (int r = 0; r < 3; r++) begin
            step(1, 0, 4'b0000);
            step(0, 0, 4'b1010);
            check("tie_id", winner_id, (r == 1) ? 3 : 1);
            step(0, 1, 4'b0000);
        end

        // False starts: before arm, and on the arm cycle itself
        step(0, 0, 4'b0001);
        check("fs_foul", foul, 4'b0001);
        step(0, 0, 4'b0000);
        step(1, 0, 4'b0000);
        step(0, 0, 4'b0001);
        check("fs_no_win", winner_valid, 0);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b1000);
        check("fs_win3", winner_id, 3);
        check("fs_foul_hold", foul, 4'b0001);
        step(0, 1, 4'b0000);
        check("fs_cleared", foul, 0);
        step(1, 0, 4'b0100);
        check("arm_press_foul", foul, 4'b0100);
        step(0, 1, 4'b0000);
        step(0, 1, 4'b0010);
        check("clear_beats_press", foul, 0);
        step(0, 0, 4'b0000);

        // Timeout after exactly T armed cycles
        step(1, 0, 4'b0000);
        for (int i = 1; i < T; i++) step(0, 0, 4'b0000);
        check("to_not_yet", timeout, 0);
        step(0, 0, 4'b0000);
        check("to_hit", timeout, 1);
        check("to_no_winner", winner_valid, 0);
        step(0, 0, 4'b0001);
        step(0, 1, 4'b0000);

        // Press in the final count cycle wins
        step(1, 0, 4'b0000);
        for (int i = 1; i < T; i++) step(0, 0, 4'b0000);
        step(0, 0, 4'b0001);
        check("last_cycle_win", winner_valid, 1);
        check("last_cycle_no_to", timeout, 0);

        // Button held through clear and arm is not a press
        step(0, 0, 4'b0010);
        step(0, 1, 4'b0010);
        step(1, 0, 4'b0010);
        step(0, 0, 4'b0010);
        step(0, 0, 4'b0010);
        check("held_no_win", winner_valid, 0);
        step(0, 0, 4'b0000);
        step(0, 0, 4'b0010);
        check("repress_id", winner_id, 1);
        step(1, 1, 4'b0000);
        check("clear_arm_armed", armed, 0);
        check("clear_arm_wv", winner_valid, 0);
        step(0, 0, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
